// File: rtl/rom_block_copier.sv
// rom_block_copier: copies a run of ROM bytes into a writable memory, one byte per cycle.
// Optional build macro COPY_CHECKSUM_EN adds an 8-bit running sum of the bytes written.
`default_nettype none

module rom_block_copier #(
    parameter int          ADDR_BITS = 14,
    parameter logic [15:0] SRC_BASE  = 16'hC000,
    parameter logic [15:0] DST_BASE  = 16'h4000
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 start,
    input  logic [ADDR_BITS:0]   len,
    output logic                 busy,
    output logic                 done,
    output logic                 rom_enable,
    output logic                 read,
    output logic [15:0]          rom_addr,
    input  logic [7:0]           rom_data,
    output logic                 ram_we,
    output logic [15:0]          ram_addr,
    output logic [7:0]           ram_wdata,
    input  logic                 ram_ready
`ifdef COPY_CHECKSUM_EN
    ,
    output logic [7:0]           checksum
`endif
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_FETCH = 2'd1,
        S_WRITE = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [ADDR_BITS:0] CNT_ONE  = {{ADDR_BITS{1'b0}}, 1'b1};
    localparam logic [ADDR_BITS:0] CNT_ZERO = '0;

    state_t              state_q, state_d;
    logic [ADDR_BITS:0]  cnt_q, cnt_d;
    logic [15:0]         idx_q, idx_d;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        idx_d      = idx_q;
        busy       = 1'b0;
        done       = 1'b0;
        rom_enable = 1'b0;
        rom_addr   = '0;
        ram_we     = 1'b0;
        ram_addr   = '0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    cnt_d   = len;
                    idx_d   = '0;
                    state_d = (len == CNT_ZERO) ? S_DONE : S_FETCH;
                end
            end
            S_FETCH: begin
                busy       = 1'b1;
                rom_enable = 1'b1;
                rom_addr   = SRC_BASE + idx_q;
                state_d    = S_WRITE;
            end
            S_WRITE: begin
                busy     = 1'b1;
                ram_we   = 1'b1;
                ram_addr = DST_BASE + idx_q;
                rom_addr = SRC_BASE + idx_q;
                // Prefetch the next byte only once the current one is accepted,
                // so the ROM output register never overwrites unwritten data.
                if (ram_ready) begin
                    if (cnt_q > CNT_ONE) begin
                        rom_enable = 1'b1;
                        rom_addr   = SRC_BASE + idx_q + 16'd1;
                        idx_d      = idx_q + 16'd1;
                        cnt_d      = cnt_q - CNT_ONE;
                    end else begin
                        state_d = S_DONE;
                    end
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    assign read      = rom_enable;
    assign ram_wdata = rom_data;

`ifdef COPY_CHECKSUM_EN
    logic [7:0] sum_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sum_q <= '0;
        end else if ((state_q == S_IDLE) && start) begin
            sum_q <= '0;
        end else if (ram_we && ram_ready) begin
            sum_q <= sum_q + ram_wdata;
        end
    end

    assign checksum = sum_q;
`endif

endmodule

`default_nettype wire

// File: doc/rom_block_copier.md
Name: rom_block_copier

Overview:
- Initiator-side engine for the 16-bit-address, 8-bit-data synchronous ROM read port: drives enable/read/address and consumes read data one cycle later.
- Copies a run of bytes from ROM into a writable memory with a ready handshake, e.g. shadowing boot code into RAM before releasing the 65C02 from reset.
- Sits between the ROM read port and a RAM write port; started by a single pulse from the system controller.

Parameters:
- ADDR_BITS, 14, width of the length counter; maximum copy length is 2**ADDR_BITS bytes.
- SRC_BASE, 16'hC000, first ROM byte address.
- DST_BASE, 16'h4000, first destination byte address.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- start  in  1  one-cycle request, sampled only in IDLE.
- len  in  ADDR_BITS+1  byte count, sampled with start; legal values 0..2**ADDR_BITS.
- busy  out  1  high from the cycle after start is accepted until the last write is accepted.
- done  out  1  one-cycle pulse after completion.
- rom_enable  out  1  ROM read strobe.
- read  out  1  equals rom_enable.
- rom_addr  out  16  ROM byte address.
- rom_data  in  8  ROM data; valid the cycle after rom_enable, held while rom_enable is low.
- ram_we  out  1  write request.
- ram_addr  out  16  destination address.
- ram_wdata  out  8  write data, combinationally equal to rom_data.
- ram_ready  in  1  write accepted this cycle when ram_we && ram_ready.

Behaviour:
- Reset values: state IDLE; counters 0; all outputs 0 (busy, done, rom_enable, read, ram_we, rom_addr, ram_addr).
- States:
  - IDLE: start && len!=0 -> FETCH; latch cnt=len, idx=0. start && len==0 -> DONE with no ROM or RAM access.
  - FETCH (one cycle): rom_enable=read=1, rom_addr=SRC_BASE+idx -> WRITE.
  - WRITE: ram_we=1, ram_addr=DST_BASE+idx, ram_wdata=rom_data.
    - ram_ready=0: stay in WRITE; rom_enable=0 so rom_data holds; all outputs stable.
    - ram_ready=1 and cnt>1: same cycle assert rom_enable=read=1, rom_addr=SRC_BASE+idx+1; idx++, cnt--; stay in WRITE. Sustained throughput is 1 byte/cycle.
    - ram_ready=1 and cnt==1: -> DONE.
  - DONE: done=1 for one cycle, busy=0 -> IDLE.
- Latency: start at edge T gives first rom_enable in cycle T+1 and the first ram_we in cycle T+2. With ram_ready held high, N bytes finish with done in cycle T+N+2.
- busy=1 in FETCH and WRITE only.
- Address arithmetic is modulo 2**16 on both sides. SRC_BASE+idx past 16'hFFFF wraps to 16'h0000; the same applies to the destination.
- rom_enable is never asserted while a ram_we is pending unaccepted, so no ROM data is lost.
- start outside IDLE (including in DONE) is ignored; no queueing.
- len greater than 2**ADDR_BITS is truncated to the ADDR_BITS+1-bit port width; no further check.
- Reset asserted mid-copy: immediate return to IDLE, outputs to reset values, no done pulse; partial destination contents are unspecified.
- rom_enable, read, ram_we and the addresses are Mealy outputs of state, counters and ram_ready; no combinational path from rom_data to any control output.

Optional Feature:
- COPY_CHECKSUM_EN defined: adds output checksum [7:0].
  - Cleared to 0 when start is accepted.
  - Adds ram_wdata modulo 256 on every accepted write.
  - Holds its value after done until the next accepted start; reset value 0.
- Undefined: no checksum port, no adder; behaviour otherwise identical.

Test Plan:
- len=4, ROM[C000..C003]=11,22,33,44, ram_ready=1 -> rom_enable cycles T+1..T+4; RAM writes 4000..4003=11,22,33,44 in cycles T+2..T+5; done in T+6; checksum 0xAA when COPY_CHECKSUM_EN is defined.
- len=0 -> no rom_enable, no ram_we; done pulses one cycle after start; busy never high.
- len=3, ram_ready low for 3 cycles on the second write -> ram_addr=4001 and ram_wdata stable during the stall, rom_enable low during the stall; all 3 bytes correct.
- SRC_BASE=FFFE, DST_BASE=FFFF, len=3 -> reads FFFE, FFFF, 0000; writes FFFF, 0000, 0001.
- start pulsed in WRITE and in DONE -> ignored; exactly one done per accepted start.
- reset asserted after 2 of 8 writes -> all outputs 0 asynchronously; no done; a new start with len=1 then copies correctly.
